// File: rtl/posit_decode_pipe.sv
// Posit decoder, 3-stage pipeline.
// Stage 1 takes the magnitude. Stage 2 measures the regime run.
// Stage 3 splits out exponent and fraction and forms the scale.
// All stages advance together whenever the output register is free or being consumed.
module posit_decode_pipe #(
  parameter  int POSIT_WIDTH = 32,
  parameter  int POSIT_ES    = 2,
  localparam int SCALE_W     = $clog2(POSIT_WIDTH) + 1 + POSIT_ES,
  localparam int FRAC_W      = POSIT_WIDTH - 3 - POSIT_ES
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [POSIT_WIDTH-1:0]    posit_word_i,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      sign_o,
  output logic signed [SCALE_W-1:0] scale_o,
  output logic [FRAC_W-1:0]         fraction_o,
  output logic                      zero_o,
  output logic                      nar_o
);
  localparam int N  = POSIT_WIDTH;
  localparam int MW = $clog2(N) + 1;   // holds run length 1..N-1 and the shift N
  localparam int RW = N - 3;           // bits left after sign, regime and terminator: {e, frac}

  typedef struct packed {
    logic         sign;
    logic         zero;
    logic         nar;
    logic [N-2:0] mag;
  } s1_t;

  typedef struct packed {
    logic                      sign;
    logic                      zero;
    logic                      nar;
    logic signed [SCALE_W-1:0] k;
    logic [RW-1:0]             rem;
  } s2_t;

  logic [3:1] vld_q;
  logic [3:0] vld_pipe;
  logic       advance;

  s1_t s1_d, s1_q;
  s2_t s2_d, s2_q;

  logic [N-2:0]              run_bits;
  logic [MW-1:0]             run_len;
  logic                      found;
  logic signed [SCALE_W-1:0] run_ext;
  logic [SCALE_W-1:0]        e_val;
  logic signed [SCALE_W-1:0] scale_d;
  logic [FRAC_W-1:0]         frac_d;

  assign vld_pipe  = {vld_q, in_valid};
  assign out_valid = vld_pipe[3];
  assign advance   = out_ready | ~vld_pipe[3];
  assign in_ready  = advance;

  // Stage 1: flag the special encodings and fold negative words to their magnitude
  always_comb begin
    s1_d.sign = posit_word_i[N-1];
    s1_d.zero = (posit_word_i == '0);
    s1_d.nar  = (posit_word_i == {1'b1, {(N-1){1'b0}}});
    s1_d.mag  = posit_word_i[N-1] ? (~posit_word_i[N-2:0] + 1'b1) : posit_word_i[N-2:0];
  end

  // Stage 2: regime run length. Invert when the run is ones, then count leading zeros.
  // Bit N-2 of run_bits is always 0, so any run stops at or below it.
  always_comb begin
    run_bits = s1_q.mag[N-2] ? ~s1_q.mag : s1_q.mag;
    run_len  = MW'(N - 1);
    found    = 1'b0;
    for (int i = N - 2; i >= 0; i--) begin
      if (!found && run_bits[i]) begin
        run_len = MW'(N - 2 - i);
        found   = 1'b1;
      end
    end
    run_ext   = SCALE_W'(run_len);
    s2_d.sign = s1_q.sign;
    s2_d.zero = s1_q.zero;
    s2_d.nar  = s1_q.nar;
    s2_d.k    = s1_q.mag[N-2] ? run_ext - SCALE_W'(1) : -run_ext;
    // The run and its terminator are dropped; the two low bits are always zero after the shift
    s2_d.rem  = RW'((s1_q.mag << (run_len + MW'(1))) >> 2);
  end

  // The exponent is the top ES bits of the remainder; none when ES is 0
  if (POSIT_ES > 0) begin : g_exp
    assign e_val = SCALE_W'(s2_q.rem[RW-1 -: POSIT_ES]);
  end else begin : g_noexp
    assign e_val = '0;
  end

  // Stage 3: combine regime and exponent into the scale; force zero and NaR to 0
  always_comb begin
    scale_d = (s2_q.k <<< POSIT_ES) + $signed(e_val);
    frac_d  = s2_q.rem[FRAC_W-1:0];
    if (s2_q.zero || s2_q.nar) begin
      scale_d = '0;
      frac_d  = '0;
    end
  end

  // Valid shift register, gated by the shared advance
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          vld_q <= '0;
    else if (advance) vld_q <= vld_pipe[2:0];
  end

  // Data registers for all three stages, held bit-stable during a stall
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q       <= '0;
      s2_q       <= '0;
      sign_o     <= 1'b0;
      scale_o    <= '0;
      fraction_o <= '0;
      zero_o     <= 1'b0;
      nar_o      <= 1'b0;
    end else if (advance) begin
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      sign_o     <= s2_q.sign;
      scale_o    <= scale_d;
      fraction_o <= frac_d;
      zero_o     <= s2_q.zero;
      nar_o      <= s2_q.nar;
    end
  end
endmodule
